// File: rtl/readout_sequencer.sv
// readout_sequencer
//
// Walks every channel enabled in a latched channel mask and reads each of its
// counter words autonomously. For every word it drives the one-hot channel
// select and the word index, waits a settle time, samples the counter bus and
// pushes {data, channel, word} into a small show-ahead output FIFO.
//
// Ports:
//   clk, rst         single clock, asynchronous active-high reset
//   start, abort     one-cycle request / cancel pulses from the instruction driver
//   channel_mask     channel enables, captured on an accepted start
//   cnt_data         counter word for the currently selected channel/word
//   load_cnt_ser     one-hot channel select (0 when idle)
//   select_reg       word index (3'b111 when idle)
//   out_data/out_ch/out_word, out_valid, out_ready   FIFO head and handshake
//   busy             high in every state except IDLE
//   done             one-cycle pulse on normal completion
//   dbg_state        current sequencer state, for observation only
//
// Output handshake: out_valid is high whenever the FIFO holds a word and
// out_data/out_ch/out_word then show the oldest word. A word is consumed on
// every rising edge where out_valid && out_ready; out_valid never drops and
// the head never changes until that happens (except on abort or reset).

module readout_sequencer #(
   parameter int NUM_CH        = 8,
   parameter int WORDS_PER_CH  = 7,
   parameter int SETTLE_CYCLES = 2,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [NUM_CH-1:0] channel_mask,
   input  logic [7:0]        cnt_data,
   output logic [NUM_CH-1:0] load_cnt_ser,
   output logic [2:0]        select_reg,
   output logic [7:0]        out_data,
   output logic [2:0]        out_ch,
   output logic [2:0]        out_word,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic [2:0]        dbg_state
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETUP   = 3'd1,
      S_CAPTURE = 3'd2,
      S_DRAIN   = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_CH-1:0]   mask_q, mask_d;
   logic [2:0]          ch_q, ch_d;
   logic [2:0]          word_q, word_d;
   logic [SET_W-1:0]    settle_q, settle_d;
   logic [NUM_CH-1:0]   load_q, load_d;
   logic [2:0]          sel_q, sel_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [13:0]         mem_q [FIFO_DEPTH];
   logic [13:0]         mem_d [FIFO_DEPTH];

   logic                push, pop, flush, fifo_full;
   logic                first_found, next_found;
   logic [2:0]          first_ch, next_ch;
   logic [13:0]         head;

   // Priority searches: the descending loop leaves the lowest matching index.
   // first_* looks at the incoming mask (for start), next_* at latched bits
   // strictly above the current channel, so masked channels cost no cycles.
   always_comb begin
      first_found = 1'b0;
      first_ch    = 3'd0;
      next_found  = 1'b0;
      next_ch     = 3'd0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (channel_mask[i]) begin
            first_found = 1'b1;
            first_ch    = 3'(i);
         end
         if (mask_q[i] && (i > int'(ch_q))) begin
            next_found = 1'b1;
            next_ch    = 3'(i);
         end
      end
   end

   assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));

   // Sequencer next-state and registered drive values
   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      ch_d     = ch_q;
      word_d   = word_q;
      settle_d = settle_q;
      load_d   = load_q;
      sel_d    = sel_q;
      push     = 1'b0;
      flush    = 1'b0;

      if (abort) begin
         state_d = S_IDLE;
         flush   = 1'b1;
         load_d  = '0;
         sel_d   = 3'b111;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  mask_d = channel_mask;
                  if (!first_found) begin
                     state_d = S_DONE;
                  end else begin
                     state_d  = S_SETUP;
                     ch_d     = first_ch;
                     word_d   = 3'd0;
                     settle_d = '0;
                     load_d   = NUM_CH'(1) << first_ch;
                     sel_d    = 3'd0;
                  end
               end
            end
            S_SETUP: begin
               if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                  state_d = S_CAPTURE;
               end else begin
                  settle_d = settle_q + SET_W'(1);
               end
            end
            S_CAPTURE: begin
               // When full, stay here with the drive held and retry next cycle
               if (!fifo_full) begin
                  push = 1'b1;
                  if (word_q != 3'(WORDS_PER_CH - 1)) begin
                     state_d  = S_SETUP;
                     word_d   = word_q + 3'(1);
                     settle_d = '0;
                     sel_d    = word_q + 3'(1);
                  end else if (next_found) begin
                     state_d  = S_SETUP;
                     ch_d     = next_ch;
                     word_d   = 3'd0;
                     settle_d = '0;
                     load_d   = NUM_CH'(1) << next_ch;
                     sel_d    = 3'd0;
                  end else begin
                     state_d = S_DRAIN;
                     load_d  = '0;
                     sel_d   = 3'b111;
                  end
               end
            end
            S_DRAIN: begin
               if (count_q == '0) begin
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
               load_d  = '0;
               sel_d   = 3'b111;
            end
         endcase
      end

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // Output FIFO. Push is gated only by the registered count, so a push into
   // a full FIFO is refused even when a pop happens in the same cycle.
   assign pop = (count_q != '0) && out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = {cnt_data, ch_q, word_q};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         mask_q   <= '0;
         ch_q     <= 3'd0;
         word_q   <= 3'd0;
         settle_q <= '0;
         load_q   <= '0;
         sel_q    <= 3'b111;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         mem_q    <= '{default: '0};
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         ch_q     <= ch_d;
         word_q   <= word_d;
         settle_q <= settle_d;
         load_q   <= load_d;
         sel_q    <= sel_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

   // Head fields read as zero while empty so reset and flush show clean values
   assign head         = mem_q[rd_ptr_q];
   assign out_valid    = (count_q != '0);
   assign out_data     = out_valid ? head[13:6] : 8'h00;
   assign out_ch       = out_valid ? head[5:3]  : 3'd0;
   assign out_word     = out_valid ? head[2:0]  : 3'd0;
   assign load_cnt_ser = load_q;
   assign select_reg   = sel_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Bench for readout_sequencer: table of whole-readout vectors, hand-written
// backpressure / abort / reset sequences, and random-mask runs with random
// out_ready, all scored against a queue of expected words built from the
// channel mask.

module tb_readout_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] channel_mask = 8'h00;
   logic [7:0] cnt_data;
   logic [7:0] load_cnt_ser;
   logic [2:0] select_reg;
   logic [7:0] out_data;
   logic [2:0] out_ch;
   logic [2:0] out_word;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       busy;
   logic       done;
   logic [2:0] dbg_state;

   int total = 0;
   int bad   = 0;
   logic [13:0] exp_q[$];

   typedef struct {
      logic [7:0] mask;
      int         restart_at;
      int         exp_pops;
      int         exp_first_valid;
      int         exp_done_cyc;
      int         exp_first;
      int         exp_last;
      int         exp_load;
   } vec_t;

   vec_t vecs[6];

   readout_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .channel_mask (channel_mask),
      .cnt_data     (cnt_data),
      .load_cnt_ser (load_cnt_ser),
      .select_reg   (select_reg),
      .out_data     (out_data),
      .out_ch       (out_ch),
      .out_word     (out_word),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .busy         (busy),
      .done         (done),
      .dbg_state    (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Counter bank model: word = {channel, word index}
   logic [3:0] bench_ch;
   always_comb begin
      bench_ch = 4'h0;
      for (int i = 0; i < 8; i++) begin
         if (load_cnt_ser[i]) bench_ch = 4'(i);
      end
      cnt_data = {bench_ch, 1'b0, select_reg};
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference: every enabled channel in ascending order, words 0..6,
   // entry = {data = ch*16 + w, ch, w}
   task automatic build_expected(input logic [7:0] mask);
      exp_q.delete();
      for (int c = 0; c < 8; c++) begin
         if (mask[c]) begin
            for (int w = 0; w < 7; w++) begin
               exp_q.push_back(14'((c * 16 + w) * 64 + c * 8 + w));
            end
         end
      end
   endtask

   // Advance one cycle; a handshake seen now is consumed at the coming edge
   task automatic tick();
      logic [13:0] got;
      logic [13:0] want;
      if (out_valid && out_ready) begin
         got = {out_data, out_ch, out_word};
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL word_extra: got=%0h expected=none", got);
         end else begin
            want = exp_q.pop_front();
            check("word", int'(got), int'(want));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_readout(input logic [7:0] mask, input int restart_at, input bit rand_ready,
                              output int n_pops, output int first_valid, output int done_cyc,
                              output int n_done, output int busy_after, output int saw_load,
                              output int first_w, output int last_w);
      int cyc;
      build_expected(mask);
      n_pops = 0; first_valid = -1; done_cyc = -1; n_done = 0;
      busy_after = -1; saw_load = 0; first_w = -1; last_w = -1;
      channel_mask = mask;
      start = 1'b1;
      out_ready = 1'b1;
      cyc = 0;
      while (cyc < 3000 && !(done_cyc >= 0 && cyc > done_cyc + 2)) begin
         if (cyc > 0) begin
            start = (cyc == restart_at);
            if (cyc == restart_at) channel_mask = 8'hFF;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (load_cnt_ser != 8'h00) saw_load = 1;
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = int'(busy);
         if (out_valid && out_ready) begin
            if (n_pops == 0) first_w = int'(out_data);
            last_w = int'(out_data);
            n_pops++;
         end
         tick();
         cyc++;
      end
      start = 1'b0;
      out_ready = 1'b1;
      check("queue_empty", exp_q.size(), 0);
   endtask

   task automatic check_row(input vec_t v);
      int n_pops, first_valid, done_cyc, n_done, busy_after, saw_load, first_w, last_w;
      run_readout(v.mask, v.restart_at, 1'b0, n_pops, first_valid, done_cyc, n_done,
                  busy_after, saw_load, first_w, last_w);
      check("pops", n_pops, v.exp_pops);
      check("first_valid_cycle", first_valid, v.exp_first_valid);
      check("done_cycle", done_cyc, v.exp_done_cyc);
      check("done_pulses", n_done, 1);
      check("busy_after_done", busy_after, 0);
      check("load_seen", saw_load, v.exp_load);
      check("first_word", first_w, v.exp_first);
      check("last_word", last_w, v.exp_last);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_load"}, int'(load_cnt_ser), 0);
      check({tag, "_sel"}, int'(select_reg), 7);
      check({tag, "_valid"}, int'(out_valid), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
   endtask

   initial begin
      int n, extra_done, valid_seen, busy_seen, load_seen;
      vec_t restart_row;

      vecs[0] = '{8'h29, -1, 21,  4,  66, 'h00, 'h56, 1};
      vecs[1] = '{8'h00, -1,  0, -1,   1,   -1,   -1, 0};
      vecs[2] = '{8'h01,  5,  7,  4,  24, 'h00, 'h06, 1};  // start while busy ignored
      vecs[3] = '{8'h80, -1,  7,  4,  24, 'h70, 'h76, 1};
      vecs[4] = '{8'hFF, -1, 56,  4, 171, 'h00, 'h76, 1};
      vecs[5] = '{8'h24, -1, 14,  4,  45, 'h20, 'h56, 1};

      // reset values while rst is held
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      check("reset_out_data", int'(out_data), 0);
      check("reset_out_ch", int'(out_ch), 0);
      check("reset_out_word", int'(out_word), 0);
      rst = 1'b0;
      tick();

      // table-driven whole readouts
      for (int i = 0; i < 6; i++) begin
         check_row(vecs[i]);
         repeat (2) tick();
      end

      // backpressure: FIFO fills, sequencer stalls on ch0 word 4
      build_expected(8'hFF);
      channel_mask = 8'hFF;
      out_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (29) tick();
      check("stall_valid", int'(out_valid), 1);
      check("stall_load", int'(load_cnt_ser), 'h01);
      check("stall_sel", int'(select_reg), 4);
      check("stall_busy", int'(busy), 1);
      check("stall_head", int'(out_data), 'h00);
      out_ready = 1'b1;
      n = 0;
      extra_done = 0;
      for (int k = 0; k < 3000 && extra_done == 0; k++) begin
         if (done) extra_done++;
         if (out_valid && out_ready) n++;
         tick();
      end
      check("bp_pops", n, 56);
      check("bp_done", extra_done, 1);
      check("bp_queue_empty", exp_q.size(), 0);
      repeat (2) tick();

      // abort after the 10th pop
      build_expected(8'hFF);
      channel_mask = 8'hFF;
      out_ready = 1'b1;
      start = 1'b1;
      n = 0;
      extra_done = 0;
      for (int k = 0; k < 400 && n < 10; k++) begin
         if (out_valid && out_ready) n++;
         if (done) extra_done++;
         tick();
         start = 1'b0;
      end
      check("abort_pops_before", n, 10);
      out_ready = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      exp_q.delete();
      check_idle_outputs("abort");
      valid_seen = 0;
      repeat (20) begin
         if (done) extra_done++;
         if (out_valid) valid_seen++;
         tick();
      end
      check("abort_no_done", extra_done, 0);
      check("abort_stays_empty", valid_seen, 0);
      restart_row = '{8'h03, -1, 14, 4, 45, 'h00, 'h16, 1};
      check_row(restart_row);
      repeat (2) tick();

      // start and abort together in IDLE
      channel_mask = 8'hFF;
      out_ready = 1'b1;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      busy_seen = int'(busy);
      load_seen = int'(load_cnt_ser != 8'h00);
      valid_seen = 0;
      repeat (8) begin
         if (busy) busy_seen = 1;
         if (load_cnt_ser != 8'h00) load_seen = 1;
         if (out_valid) valid_seen = 1;
         tick();
      end
      check("start_abort_busy", busy_seen, 0);
      check("start_abort_load", load_seen, 0);
      check("start_abort_valid", valid_seen, 0);

      // asynchronous reset mid-run
      build_expected(8'hFF);
      channel_mask = 8'hFF;
      out_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (19) tick();
      check("pre_rst_valid", int'(out_valid), 1);
      rst = 1'b1;
      #1;
      check_idle_outputs("async_rst");
      check("async_rst_out_data", int'(out_data), 0);
      check("async_rst_out_ch", int'(out_ch), 0);
      check("async_rst_out_word", int'(out_word), 0);
      exp_q.delete();
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      extra_done = 0;
      valid_seen = 0;
      repeat (10) begin
         if (done) extra_done++;
         if (out_valid) valid_seen++;
         tick();
      end
      check("rst_no_done", extra_done, 0);
      check("rst_fifo_empty", valid_seen, 0);

      // random masks with random consumer stalls
      for (int r = 0; r < 6; r++) begin
         logic [7:0] m;
         int n_pops, first_valid, done_cyc, n_done, busy_after, saw_load, first_w, last_w;
         int n_en, low_ch;
         m = 8'($urandom_range(1, 255));
         n_en = 0;
         low_ch = -1;
         for (int c = 7; c >= 0; c--) begin
            if (m[c]) begin
               n_en++;
               low_ch = c;
            end
         end
         run_readout(m, -1, 1'b1, n_pops, first_valid, done_cyc, n_done,
                     busy_after, saw_load, first_w, last_w);
         check("rand_pops", n_pops, 7 * n_en);
         check("rand_done_pulses", n_done, 1);
         check("rand_busy_after", busy_after, 0);
         check("rand_first_word", first_w, low_ch * 16);
         repeat (2) tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
